// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-SRAM loads/stores, aligns/extends load data, hands off to MEM_WB.
// Optional MEM_ALE_EN: misaligned half/word accesses skip the bus and raise out_ale.
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ls_valid,
    output logic              ts_ready,
    output logic              ts_valid,
    input  logic              ns_ready,
    input  logic              flush,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_inst,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [3:0]        in_mem_op,
    input  logic [4:0]        in_rw_addr,
    input  logic              in_rw_en,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic [DATA_W-1:0] out_rw_data,
    output logic [4:0]        out_rw_addr,
    output logic              out_rw_en
`ifdef MEM_ALE_EN
    ,
    output logic              out_ale
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_CANCEL = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDB  = 4'd1;
    localparam logic [3:0] OP_LDH  = 4'd2;
    localparam logic [3:0] OP_LDW  = 4'd3;
    localparam logic [3:0] OP_LDBU = 4'd4;
    localparam logic [3:0] OP_LDHU = 4'd5;
    localparam logic [3:0] OP_STB  = 4'd6;
    localparam logic [3:0] OP_STH  = 4'd7;
    localparam logic [3:0] OP_STW  = 4'd8;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            OP_LDB, OP_LDH, OP_LDW, OP_LDBU, OP_LDHU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            OP_STB, OP_STH, OP_STW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LDH, OP_LDHU, OP_STH: return 2'd1;
            OP_LDW, OP_STW:          return 2'd2;
            default:                 return 2'd0;
        endcase
    endfunction

`ifdef MEM_ALE_EN
    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op_size(op))
            2'd1:    return a[0];
            2'd2:    return (a != 2'd0);
            default: return 1'b0;
        endcase
    endfunction
`endif

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
        case (size)
            2'd1:    return {addr[ADDR_W-1:1], 1'b0};
            2'd2:    return {addr[ADDR_W-1:2], 2'b00};
            default: return addr;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_STB:  return 4'b0001 << a;
            OP_STH:  return a[1] ? 4'b1100 : 4'b0011;
            OP_STW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_wdata(input logic [3:0] op, input logic [DATA_W-1:0] d);
        case (op)
            OP_STB:  return {4{d[7:0]}};
            OP_STH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] load_data(input logic [3:0] op, input logic [1:0] a,
                                                    input logic [DATA_W-1:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LDB:  return {{(DATA_W-8){b[7]}}, b};
            OP_LDBU: return {{(DATA_W-8){1'b0}}, b};
            OP_LDH:  return {{(DATA_W-16){h[15]}}, h};
            OP_LDHU: return {{(DATA_W-16){1'b0}}, h};
            default: return rdata;
        endcase
    endfunction

    state_t              state_r, state_nxt_s, accept_tgt_s;
    logic                accept_s, load_done_s, ale_s, in_is_mem_s, in_is_store_s;
    logic [3:0]          op_r;
    logic [1:0]          addr_lo_r;
    logic                ts_valid_r, data_req_r, data_wr_r, out_rw_en_r, out_ale_r;
    logic [1:0]          data_size_r;
    logic [3:0]          data_wstrb_r;
    logic [ADDR_W-1:0]   data_addr_r;
    logic [DATA_W-1:0]   data_wdata_r, out_rw_data_r;
    logic [31:0]         out_pc_r, out_inst_r;
    logic [4:0]          out_rw_addr_r;

`ifdef MEM_ALE_EN
    assign ale_s   = misaligned(in_mem_op, in_alu_result[1:0]);
    assign out_ale = out_ale_r;
`else
    assign ale_s   = 1'b0;
`endif

    assign in_is_store_s = is_store(in_mem_op);
    assign in_is_mem_s   = is_load(in_mem_op) | in_is_store_s;
    assign ts_ready      = (state_r == ST_IDLE) | ((state_r == ST_DONE) & ns_ready);
    assign accept_s      = ls_valid & ts_ready & ~flush;
    assign load_done_s   = ~flush & is_load(op_r) &
                           (((state_r == ST_REQ) & data_addr_ok & data_data_ok) |
                            ((state_r == ST_WAIT) & data_data_ok));

    assign ts_valid    = ts_valid_r;
    assign data_req    = data_req_r;
    assign data_wr     = data_wr_r;
    assign data_size   = data_size_r;
    assign data_wstrb  = data_wstrb_r;
    assign data_addr   = data_addr_r;
    assign data_wdata  = data_wdata_r;
    assign out_pc      = out_pc_r;
    assign out_inst    = out_inst_r;
    assign out_rw_data = out_rw_data_r;
    assign out_rw_addr = out_rw_addr_r;
    assign out_rw_en   = out_rw_en_r;

    // Next-state logic; a flush with a bus beat still owed parks in CANCEL to swallow it.
    always_comb begin
        state_nxt_s  = state_r;
        accept_tgt_s = (in_is_mem_s & ~ale_s) ? ST_REQ : ST_DONE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = accept_tgt_s;
                else          state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (flush) begin
                    if (data_data_ok)      state_nxt_s = ST_IDLE;
                    else if (data_addr_ok) state_nxt_s = ST_CANCEL;
                    else                   state_nxt_s = ST_IDLE;
                end else if (data_addr_ok) begin
                    state_nxt_s = data_data_ok ? ST_DONE : ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (flush)             state_nxt_s = data_data_ok ? ST_IDLE : ST_CANCEL;
                else if (data_data_ok) state_nxt_s = ST_DONE;
                else                   state_nxt_s = ST_WAIT;
            end
            ST_DONE: begin
                if (flush)         state_nxt_s = ST_IDLE;
                else if (accept_s) state_nxt_s = accept_tgt_s;
                else if (ns_ready) state_nxt_s = ST_IDLE;
                else               state_nxt_s = ST_DONE;
            end
            ST_CANCEL: begin
                if (data_data_ok) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_CANCEL;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, handshake outputs, and instruction/bus fields latched on accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            ts_valid_r    <= 1'b0;
            data_req_r    <= 1'b0;
            data_wr_r     <= 1'b0;
            data_size_r   <= 2'd0;
            data_wstrb_r  <= 4'd0;
            data_addr_r   <= '0;
            data_wdata_r  <= '0;
            op_r          <= 4'd0;
            addr_lo_r     <= 2'd0;
            out_pc_r      <= 32'd0;
            out_inst_r    <= 32'd0;
            out_rw_data_r <= '0;
            out_rw_addr_r <= 5'd0;
            out_rw_en_r   <= 1'b0;
            out_ale_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ts_valid_r <= (state_nxt_s == ST_DONE);
            data_req_r <= (state_nxt_s == ST_REQ);
            if (accept_s) begin
                op_r          <= in_mem_op;
                addr_lo_r     <= in_alu_result[1:0];
                out_pc_r      <= in_pc;
                out_inst_r    <= in_inst;
                out_rw_data_r <= in_alu_result;
                out_rw_addr_r <= in_rw_addr;
                out_rw_en_r   <= in_rw_en & ~in_is_store_s & ~ale_s;
                out_ale_r     <= ale_s;
                data_wr_r     <= in_is_store_s;
                data_size_r   <= op_size(in_mem_op);
                data_wstrb_r  <= store_wstrb(in_mem_op, in_alu_result[1:0]);
                data_wdata_r  <= store_wdata(in_mem_op, in_store_data);
                data_addr_r   <= align_addr(in_alu_result[ADDR_W-1:0], op_size(in_mem_op));
            end else if (load_done_s) begin
                out_rw_data_r <= load_data(op_r, addr_lo_r, data_rdata);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; define MEM_ALE_EN to cover the misalignment trap.
module tb_mem_access_stage;

    logic        clk, rst, ls_valid, ts_ready, ts_valid, ns_ready, flush;
    logic [31:0] in_pc, in_inst, in_alu_result, in_store_data;
    logic [3:0]  in_mem_op;
    logic [4:0]  in_rw_addr;
    logic        in_rw_en;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] out_pc, out_inst, out_rw_data;
    logic [4:0]  out_rw_addr;
    logic        out_rw_en;
`ifdef MEM_ALE_EN
    logic        out_ale;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .ls_valid(ls_valid), .ts_ready(ts_ready), .ts_valid(ts_valid),
        .ns_ready(ns_ready), .flush(flush), .in_pc(in_pc), .in_inst(in_inst),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_mem_op(in_mem_op),
        .in_rw_addr(in_rw_addr), .in_rw_en(in_rw_en), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .out_pc(out_pc), .out_inst(out_inst),
        .out_rw_data(out_rw_data), .out_rw_addr(out_rw_addr), .out_rw_en(out_rw_en)
`ifdef MEM_ALE_EN
        , .out_ale(out_ale)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic en);
        ls_valid      = 1'b1;
        in_mem_op     = op;
        in_alu_result = addr;
        in_store_data = sd;
        in_rw_en      = en;
        in_rw_addr    = 5'd7;
        in_pc         = 32'h8000_0000 | addr;
        in_inst       = {28'h0, op};
        step();
        ls_valid = 1'b0;
    endtask

    // addr_ok after aw idle cycles; data_ok dw cycles after addr_ok (0 = same cycle).
    task automatic bus(input int aw, input int dw, input logic [31:0] rd);
        repeat (aw) step();
        data_addr_ok = 1'b1;
        data_rdata   = rd;
        if (dw == 0) begin
            data_data_ok = 1'b1;
            step();
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
        end else begin
            step();
            data_addr_ok = 1'b0;
            repeat (dw - 1) step();
            data_data_ok = 1'b1;
            step();
            data_data_ok = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; ls_valid = 1'b0; ns_ready = 1'b1; flush = 1'b0;
        in_pc = 32'd0; in_inst = 32'd0; in_alu_result = 32'd0; in_store_data = 32'd0;
        in_mem_op = 4'd0; in_rw_addr = 5'd0; in_rw_en = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        step();
        step();
        rst = 1'b1;
        #1;
        check_eq("rst_ts_valid", {31'd0, ts_valid}, 32'd0);
        check_eq("rst_data_req", {31'd0, data_req}, 32'd0);
        check_eq("rst_ts_ready", {31'd0, ts_ready}, 32'd1);
        check_eq("rst_out_rw_data", out_rw_data, 32'd0);
        check_eq("rst_out_pc", out_pc, 32'd0);
        check_eq("rst_out_rw_en", {31'd0, out_rw_en}, 32'd0);
`ifdef MEM_ALE_EN
        check_eq("rst_out_ale", {31'd0, out_ale}, 32'd0);
`endif

        // Non-memory op: one-cycle latency, result passes through.
        issue(4'd0, 32'h0000_1234, 32'd0, 1'b1);
        check_eq("none_ts_valid", {31'd0, ts_valid}, 32'd1);
        check_eq("none_rw_data", out_rw_data, 32'h0000_1234);
        check_eq("none_no_req", {31'd0, data_req}, 32'd0);
        check_eq("none_rw_en", {31'd0, out_rw_en}, 32'd1);
        check_eq("none_pc", out_pc, 32'h8000_1234);
        step();
        check_eq("none_drain", {31'd0, ts_valid}, 32'd0);

        // ld.b with slow bus, then hold while MEM_WB stalls.
        ns_ready = 1'b0;
        issue(4'd1, 32'h0000_1003, 32'd0, 1'b1);
        check_eq("ldb_req", {31'd0, data_req}, 32'd1);
        check_eq("ldb_addr", data_addr, 32'h0000_1003);
        check_eq("ldb_size", {30'd0, data_size}, 32'd0);
        check_eq("ldb_wstrb", {28'd0, data_wstrb}, 32'd0);
        check_eq("ldb_wr", {31'd0, data_wr}, 32'd0);
        step();
        check_eq("ldb_req_held", {31'd0, data_req}, 32'd1);
        bus(1, 3, 32'h80FF_FFFF);
        check_eq("ldb_valid", {31'd0, ts_valid}, 32'd1);
        check_eq("ldb_data", out_rw_data, 32'hFFFF_FF80);
        check_eq("ldb_rw_en", {31'd0, out_rw_en}, 32'd1);
        check_eq("ldb_rw_addr", {27'd0, out_rw_addr}, 32'd7);
        step();
        check_eq("ldb_hold_valid", {31'd0, ts_valid}, 32'd1);
        check_eq("ldb_hold_data", out_rw_data, 32'hFFFF_FF80);
        check_eq("ldb_hold_ready", {31'd0, ts_ready}, 32'd0);
        ns_ready = 1'b1;
        #1;
        check_eq("done_ready", {31'd0, ts_ready}, 32'd1);

        // Back-to-back loads of each width/extension.
        issue(4'd4, 32'h0000_1003, 32'd0, 1'b1);
        bus(0, 0, 32'h80FF_FFFF);
        check_eq("ldbu_data", out_rw_data, 32'h0000_0080);
        issue(4'd2, 32'h0000_1002, 32'd0, 1'b1);
        check_eq("ldh_size", {30'd0, data_size}, 32'd1);
        bus(1, 1, 32'h8001_1234);
        check_eq("ldh_data", out_rw_data, 32'hFFFF_8001);
        issue(4'd5, 32'h0000_1002, 32'd0, 1'b1);
        bus(0, 2, 32'h8001_1234);
        check_eq("ldhu_data", out_rw_data, 32'h0000_8001);
        issue(4'd2, 32'h0000_1000, 32'd0, 1'b1);
        bus(0, 0, 32'h1234_F00D);
        check_eq("ldh_lo_data", out_rw_data, 32'hFFFF_F00D);
        issue(4'd3, 32'h0000_1004, 32'd0, 1'b1);
        check_eq("ldw_addr", data_addr, 32'h0000_1004);
        check_eq("ldw_size", {30'd0, data_size}, 32'd2);
        bus(0, 0, 32'hDEAD_BEEF);
        check_eq("ldw_data", out_rw_data, 32'hDEAD_BEEF);

        // Stores: strobes, replication, no register write.
        issue(4'd7, 32'h0000_2002, 32'h0000_ABCD, 1'b1);
        check_eq("sth_wstrb", {28'd0, data_wstrb}, 32'h0000_000C);
        check_eq("sth_wdata", data_wdata, 32'hABCD_ABCD);
        check_eq("sth_size", {30'd0, data_size}, 32'd1);
        check_eq("sth_wr", {31'd0, data_wr}, 32'd1);
        check_eq("sth_addr", data_addr, 32'h0000_2002);
        bus(0, 1, 32'hFFFF_FFFF);
        check_eq("sth_valid", {31'd0, ts_valid}, 32'd1);
        check_eq("sth_rw_en", {31'd0, out_rw_en}, 32'd0);
        check_eq("sth_rw_data", out_rw_data, 32'h0000_2002);
        issue(4'd0, 32'h0000_0077, 32'd0, 1'b1);
        check_eq("b2b_valid", {31'd0, ts_valid}, 32'd1);
        check_eq("b2b_data", out_rw_data, 32'h0000_0077);
        issue(4'd6, 32'h0000_2001, 32'h1234_5655, 1'b1);
        check_eq("stb_wstrb", {28'd0, data_wstrb}, 32'h0000_0002);
        check_eq("stb_wdata", data_wdata, 32'h5555_5555);
        check_eq("stb_addr", data_addr, 32'h0000_2001);
        bus(0, 0, 32'd0);
        issue(4'd8, 32'h0000_2004, 32'hCAFE_F00D, 1'b1);
        check_eq("stw_wstrb", {28'd0, data_wstrb}, 32'h0000_000F);
        check_eq("stw_wdata", data_wdata, 32'hCAFE_F00D);
        bus(0, 0, 32'd0);

        // Flush after addr_ok: CANCEL swallows the late response.
        issue(4'd3, 32'h0000_4000, 32'd0, 1'b1);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("cancel_ready", {31'd0, ts_ready}, 32'd0);
        check_eq("cancel_valid", {31'd0, ts_valid}, 32'd0);
        check_eq("cancel_req", {31'd0, data_req}, 32'd0);
        ls_valid = 1'b1; in_mem_op = 4'd0; in_alu_result = 32'h0000_0099;
        step();
        check_eq("cancel_no_accept", {31'd0, ts_valid}, 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_AAAA;
        step();
        data_data_ok = 1'b0;
        ls_valid     = 1'b0;
        check_eq("cancel_idle_ready", {31'd0, ts_ready}, 32'd1);
        check_eq("cancel_idle_valid", {31'd0, ts_valid}, 32'd0);
        check_eq("cancel_discard", out_rw_data, 32'h0000_4000);
        step();
        check_eq("cancel_never_valid", {31'd0, ts_valid}, 32'd0);

        // Flush in REQ before addr_ok drops the request.
        issue(4'd3, 32'h0000_5000, 32'd0, 1'b1);
        check_eq("reqflush_req", {31'd0, data_req}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("reqflush_drop", {31'd0, data_req}, 32'd0);
        check_eq("reqflush_ready", {31'd0, ts_ready}, 32'd1);

        // Flush in DONE while stalled kills the output.
        issue(4'd0, 32'h0000_0066, 32'd0, 1'b1);
        ns_ready = 1'b0;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        ns_ready = 1'b1;
        check_eq("doneflush_valid", {31'd0, ts_valid}, 32'd0);
        check_eq("doneflush_ready", {31'd0, ts_ready}, 32'd1);

`ifdef MEM_ALE_EN
        issue(4'd3, 32'h0000_3001, 32'd0, 1'b1);
        check_eq("ale_no_req", {31'd0, data_req}, 32'd0);
        check_eq("ale_valid", {31'd0, ts_valid}, 32'd1);
        check_eq("ale_flag", {31'd0, out_ale}, 32'd1);
        check_eq("ale_rw_en", {31'd0, out_rw_en}, 32'd0);
        issue(4'd0, 32'h0000_0010, 32'd0, 1'b1);
        check_eq("ale_clear", {31'd0, out_ale}, 32'd0);
`else
        issue(4'd3, 32'h0000_3001, 32'd0, 1'b1);
        check_eq("mis_req", {31'd0, data_req}, 32'd1);
        check_eq("mis_addr", data_addr, 32'h0000_3000);
        bus(0, 0, 32'h1122_3344);
        check_eq("mis_data", out_rw_data, 32'h1122_3344);
`endif
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage between the EX/MEM register and MEM_WB.
- Issues loads/stores to the data SRAM over a req/addr_ok/data_ok bus, then aligns and extends load data.
- Presents {pc, inst, rw_data, rw_addr, rw_en} to MEM_WB with ls_valid/ts_ready/ts_valid/ns_ready handshaking.

Parameters:
- ADDR_W, 32, data bus address width
- DATA_W, 32, data bus / register width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- ls_valid  in  1  upstream valid
- ts_ready  out  1  this stage ready, combinational
- ts_valid  out  1  output valid, registered
- ns_ready  in  1  MEM_WB ready
- flush  in  1  kill in-flight instruction
- in_pc, in_inst  in  32 each  instruction pc/word
- in_alu_result  in  32  effective address, or result for non-memory ops
- in_store_data  in  32  store source register
- in_mem_op  in  4  0 none, 1 ld.b, 2 ld.h, 3 ld.w, 4 ld.bu, 5 ld.hu, 6 st.b, 7 st.h, 8 st.w; 9-15 treated as none
- in_rw_addr  in  5  destination register
- in_rw_en  in  1  register write enable
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 byte, 1 half, 2 word
- data_wstrb  out  4  byte enables
- data_addr  out  32  bus address
- data_wdata  out  32  store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response / store done
- data_rdata  in  32  read data
- out_pc, out_inst, out_rw_data  out  32 each  to MEM_WB
- out_rw_addr  out  5  to MEM_WB
- out_rw_en  out  1  to MEM_WB

Behaviour:
Reset (rst=0 at a clk edge):
- State goes to IDLE.
- All registered outputs are 0: ts_valid, data_req, every out_* field.
- ts_ready=1.

FSM states: IDLE, REQ, WAIT, DONE, CANCEL.
- ts_ready = (IDLE) | (DONE & ns_ready).
- Accept = ls_valid & ts_ready & !flush. On accept, all in_* fields are latched.
  - mem_op none: out_rw_data=in_alu_result; go to DONE. Latency 1 cycle.
  - Any load/store: go to REQ.
- REQ: data_req=1; bus fields are driven from latched values and held stable until addr_ok.
  - addr_ok & data_ok in the same cycle: go to DONE.
  - addr_ok only: go to WAIT.
- WAIT: data_req=0; on data_ok go to DONE.
  - Loads latch the aligned data into out_rw_data.
  - Stores leave out_rw_data = address.
- DONE: ts_valid=1.
  - On ns_ready: go to IDLE, or to the next state if a new accept happens in the same cycle (back-to-back issue, no bubble).
  - Without ns_ready: hold all outputs.

Flush:
- IDLE/DONE: go to IDLE, ts_valid=0.
- REQ without addr_ok: drop data_req, go to IDLE.
- REQ with addr_ok, or WAIT without data_ok: go to CANCEL.
- REQ/WAIT with data_ok in the same cycle: go to IDLE.
- CANCEL: ts_ready=0, ts_valid=0; wait for data_ok, discard data, go to IDLE.

Alignment (a = addr[1:0]):
- st.b: wstrb = 1<<a; wdata = store byte replicated ×4.
- st.h: wstrb = a[1] ? 1100 : 0011; wdata = halfword replicated ×2.
- st.w: wstrb = 1111.
- Loads: wstrb = 0000. Byte = rdata[8a+7:8a]; half = rdata[16a[1]+15:16a[1]].
- ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend.

Field passthrough:
- out_rw_en = latched in_rw_en, forced to 0 for stores.
- data_addr = latched address with size-misaligned low bits cleared.

Optional Feature:
MEM_ALE_EN
- Defined:
  - Misalignment is ld.h/ld.hu/st.h with a[0]=1, or ld.w/st.w with a≠0.
  - A misaligned op issues no bus request and goes straight to DONE.
  - In that case out_rw_en=0 and the extra output out_ale (1 bit) = 1.
  - out_ale is 0 otherwise and resets to 0.
- Undefined: no out_ale port; misaligned low bits are silently cleared as above.

Test Plan:
- Reset with rst=0 for 2 cycles, then rst=1, ls_valid=0 → ts_valid=0, data_req=0, ts_ready=1, all out_*=0.
- mem_op=0, alu_result=0x1234, rw_en=1, ns_ready=1 → next cycle ts_valid=1, out_rw_data=0x1234, no data_req.
- ld.b, addr=0x1003, rdata=0x80FFFFFF, addr_ok 2 cycles late, data_ok 3 cycles later → out_rw_data=0xFFFFFF80; ld.bu gives 0x00000080.
- st.h, addr=0x2002, store_data=0xABCD → data_wstrb=1100, data_wdata=0xABCDABCD, data_size=1, out_rw_en=0.
- ld.w accepted with addr_ok, flush next cycle, data_ok 2 cycles later → CANCEL state, ts_ready=0, never ts_valid; IDLE after data_ok.
- MEM_ALE_EN defined: ld.w at 0x3001 → no data_req, ts_valid=1 after 1 cycle, out_ale=1, out_rw_en=0.
